multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control sequencer for the 32-bit MIPS-subset datapath. It replaces the single-cycle decode with a registered FSM, so that one ALU and one unified memory port are shared across the fetch, decode, execute, memory and writeback phases of each instruction. It sits beside the datapath, takes the opcode, ALU flags and a memory-ready handshake, and drives every mux select and write enable.

## Interface
- No parameters; the opcode map is fixed (see Operation).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction bits [31:26], taken from the instruction register.
- zero  in  1  ALU zero flag, valid in the EXEC cycle.
- neg  in  1  ALU negative flag, valid in the EXEC cycle.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load, qualified internally by the branch condition.
- pc_source  out  2  0 = ALU result (PC+4), 1 = branch target, 2 = jump address.
- iord  out  1  memory address select: 0 = PC, 1 = ALU out register.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write.
- regdst  out  2  destination select: 0 = rt, 1 = rd, 2 = $31.
- memtoreg  out  2  write-back data: 0 = ALU out, 1 = MDR, 2 = PC+4.
- alusrca  out  1  ALU A input: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B input: 0 = rt, 1 = 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
- zext  out  1  selects zero-extension on the immediate path.
- aluop  out  3  passed to alucont.
- state  out  4  current state encoding, for debug.
- illegal  out  1  sticky; set when an unknown opcode is decoded.

## Operation
- Opcodes:
  - R-type: 6'h00
  - lw: 6'h23
  - sw: 6'h2B
  - beq: 6'h04
  - j: 6'h02
  - nandi: 6'h0E
  - blezal: 6'h16
  - jalpc: 6'h1F
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=15.
- FETCH
  - Asserts mem_read, iord=0, alusrca=0, alusrcb=1, aluop=0 (add).
  - While mem_ready=0: holds FETCH with no other write enables.
  - When mem_ready=1: asserts ir_write and pc_write (pc_source=0), then moves to DECODE.
- DECODE
  - Drives alusrca=0, alusrcb=3, aluop=0 to form the branch target.
  - j: asserts pc_write, pc_source=2; goes to FETCH.
  - jalpc: asserts reg_write, regdst=2, memtoreg=2, pc_write, pc_source=2; goes to FETCH.
  - Unknown opcode: goes to TRAP.
  - All other opcodes: go to EXEC.
- EXEC
  - R-type: alusrca=1, alusrcb=0, aluop=2; goes to WB.
  - lw/sw: alusrca=1, alusrcb=2, aluop=0; goes to MEM.
  - nandi: alusrca=1, alusrcb=2, zext=1, aluop=5; goes to WB.
  - beq: alusrca=1, alusrcb=0, aluop=1, pc_write_cond=1, pc_source=1; the PC loads only if zero=1. Goes to FETCH.
  - blezal: alusrca=1, alusrcb=0, aluop=1.
    - If (zero|neg)=1: pc_write=1, pc_source=1, reg_write=1, regdst=2, memtoreg=2.
    - Goes to FETCH.
- MEM
  - iord=1; lw asserts mem_read, sw asserts mem_write.
  - Strobes stay held until mem_ready=1.
  - On ready: lw goes to WB; sw goes to FETCH.
- WB
  - reg_write=1.
  - R-type: regdst=1, memtoreg=0.
  - lw: regdst=0, memtoreg=1.
  - nandi: regdst=0, memtoreg=0.
  - Goes to FETCH.
- TRAP
  - illegal=1 and all enables are 0.
  - Stays in TRAP until reset.
- Outputs are a Moore/Mealy mix: decoded combinationally from the state register and opcode/flags. The state register is the only storage, apart from illegal and the optional counters.

## Timing
- Reset (async assert, rst_n low):
  - state=FETCH, illegal=0, counters=0.
  - All outputs are 0 except the FETCH defaults.
  - FETCH defaults are suppressed while rst_n=0, so mem_read=0 during reset.
- Deassertion is synchronous with respect to the next rising clk.
- Cycle counts with mem_ready tied high:
  - R-type / nandi: 4
  - lw: 5
  - sw: 4
  - beq / blezal: 3
  - j / jalpc: 2
- Each mem_ready=0 cycle in FETCH or MEM adds exactly one cycle.
- A write enable is never asserted in a cycle where the state is holding for mem_ready, except mem_write itself.
- Reset asserted mid-instruction aborts the instruction immediately. No partial reg_write or mem_write occurs after rst_n falls.

## Configuration
- MULTICYCLE_CTRL_PERF_EN
  - Defined: adds outputs cycle_cnt[31:0] and retire_cnt[31:0].
    - cycle_cnt increments every cycle outside reset and TRAP.
    - retire_cnt increments on every transition into FETCH from a non-FETCH state.
    - Both counters wrap at 2^32.
  - Undefined: these ports and registers are absent; behaviour is otherwise identical.

## Test plan
- Reset, then opcode=6'h00 with mem_ready=1: states 0,1,2,4,0. reg_write=1 only in WB with regdst=1. With PERF_EN, retire_cnt=1 after 4 cycles.
- lw (6'h23) with mem_ready low for 2 cycles in MEM: mem_read and iord=1 held for 3 cycles. WB follows with memtoreg=1, 7 cycles total.
- beq with zero=0, then zero=1: pc_write_cond=1 in EXEC both times and pc_write=0. Next FETCH occurs 3 cycles after the start.
- blezal with neg=1: EXEC asserts pc_write, reg_write, regdst=2, memtoreg=2. With zero=0 and neg=0, no write enables are asserted.
- opcode=6'h3F: TRAP after DECODE; illegal=1 sticky with all enables 0 for 10 cycles. rst_n low then high returns to FETCH with illegal=0.
- rst_n pulsed low during MEM of sw with mem_ready=0: mem_write drops asynchronously and state=FETCH; with PERF_EN, both counters read 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control sequencer: one registered FSM drives all datapath selects/enables.
// Optional MULTICYCLE_CTRL_PERF_EN adds cycle_cnt/retire_cnt performance counters.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zext,
  output logic [2:0] aluop,
  output logic [3:0] state,
  output logic       illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
`endif
);

  // state  | meaning
  // FETCH  | read instruction at PC, PC += 4 on ready
  // DECODE | form branch target; j/jalpc complete here
  // EXEC   | ALU operation; branches complete here
  // MEM    | data access for lw/sw, holds until ready
  // WB     | register file write
  // TRAP   | unknown opcode, parked until reset
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_NANDI  = 6'h0E;
  localparam logic [5:0] OP_BLEZAL = 6'h16;
  localparam logic [5:0] OP_JALPC  = 6'h1F;

  state_t cur_state, nxt_state;
  logic   illegal_q;
  logic   known_op;

  always_comb begin
    known_op = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_NANDI, OP_BLEZAL, OP_JALPC: known_op = 1'b1;
      default: known_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (cur_state == S_DECODE && !known_op) begin
      illegal_q <= 1'b1;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH:  if (mem_ready) nxt_state = S_DECODE;
      S_DECODE: begin
        if (!known_op)                               nxt_state = S_TRAP;
        else if (opcode == OP_J || opcode == OP_JALPC) nxt_state = S_FETCH;
        else                                         nxt_state = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE, OP_NANDI: nxt_state = S_WB;
          OP_LW, OP_SW:       nxt_state = S_MEM;
          default:            nxt_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) nxt_state = (opcode == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:     nxt_state = S_FETCH;
      S_TRAP:   nxt_state = S_TRAP;
      default:  nxt_state = S_FETCH;
    endcase
  end

  // Outputs are forced low while rst_n is asserted so no strobe leaks during reset.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    regdst        = 2'd0;
    memtoreg      = 2'd0;
    alusrca       = 1'b0;
    alusrcb       = 2'd0;
    zext          = 1'b0;
    aluop         = 3'd0;
    if (rst_n) begin
      case (cur_state)
        S_FETCH: begin
          mem_read = 1'b1;
          alusrcb  = 2'd1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          alusrcb = 2'd3;
          if (opcode == OP_J || opcode == OP_JALPC) begin
            pc_write  = 1'b1;
            pc_source = 2'd2;
          end
          if (opcode == OP_JALPC) begin
            reg_write = 1'b1;
            regdst    = 2'd2;
            memtoreg  = 2'd2;
          end
        end
        S_EXEC: begin
          alusrca = 1'b1;
          case (opcode)
            OP_RTYPE: aluop = 3'd2;
            OP_LW, OP_SW: alusrcb = 2'd2;
            OP_NANDI: begin
              alusrcb = 2'd2;
              zext    = 1'b1;
              aluop   = 3'd5;
            end
            OP_BEQ: begin
              aluop         = 3'd1;
              pc_write_cond = 1'b1;
              pc_source     = 2'd1;
            end
            OP_BLEZAL: begin
              aluop = 3'd1;
              if (zero | neg) begin
                pc_write  = 1'b1;
                pc_source = 2'd1;
                reg_write = 1'b1;
                regdst    = 2'd2;
                memtoreg  = 2'd2;
              end
            end
            default: aluop = 3'd0;
          endcase
        end
        S_MEM: begin
          iord      = 1'b1;
          mem_read  = (opcode == OP_LW);
          mem_write = (opcode == OP_SW);
        end
        S_WB: begin
          reg_write = 1'b1;
          if (opcode == OP_RTYPE) regdst = 2'd1;
          if (opcode == OP_LW)    memtoreg = 2'd1;
        end
        default: pc_write = 1'b0;
      endcase
    end
  end

  assign state   = cur_state;
  assign illegal = illegal_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt  <= 32'd0;
      retire_cnt <= 32'd0;
    end else begin
      if (cur_state != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (nxt_state == S_FETCH && cur_state != S_FETCH) retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: per-cycle vectors plus trap and mid-instruction reset sequences.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero, neg, mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write;
  logic       alusrca, zext, illegal;
  logic [1:0] pc_source, regdst, memtoreg, alusrcb;
  logic [2:0] aluop;
  logic [3:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retire_cnt;
`endif

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .neg(neg), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .zext(zext),
    .aluop(aluop), .state(state), .illegal(illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Control word: {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
  //                reg_write, regdst, memtoreg, alusrca, alusrcb, zext, aluop}
  logic [19:0] act;
  assign act = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                reg_write, regdst, memtoreg, alusrca, alusrcb, zext, aluop};

  localparam logic [19:0] PCW   = 20'd1 << 19;
  localparam logic [19:0] PWC   = 20'd1 << 18;
  localparam logic [19:0] PSRC1 = 20'd1 << 16;
  localparam logic [19:0] PSRC2 = 20'd2 << 16;
  localparam logic [19:0] IORD  = 20'd1 << 15;
  localparam logic [19:0] MRD   = 20'd1 << 14;
  localparam logic [19:0] MWR   = 20'd1 << 13;
  localparam logic [19:0] IRW   = 20'd1 << 12;
  localparam logic [19:0] RGW   = 20'd1 << 11;
  localparam logic [19:0] RD1   = 20'd1 << 9;
  localparam logic [19:0] RD2   = 20'd2 << 9;
  localparam logic [19:0] MTR1  = 20'd1 << 7;
  localparam logic [19:0] MTR2  = 20'd2 << 7;
  localparam logic [19:0] ASA   = 20'd1 << 6;
  localparam logic [19:0] BSRC1 = 20'd1 << 4;
  localparam logic [19:0] BSRC2 = 20'd2 << 4;
  localparam logic [19:0] BSRC3 = 20'd3 << 4;
  localparam logic [19:0] ZX    = 20'd1 << 3;
  localparam logic [19:0] OP1   = 20'd1;
  localparam logic [19:0] OP2   = 20'd2;
  localparam logic [19:0] OP5   = 20'd5;

  localparam logic [19:0] F_STALL = MRD | BSRC1;
  localparam logic [19:0] F_GO    = MRD | BSRC1 | IRW | PCW;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        n;
    logic        rdy;
    logic [3:0]  st;
    logic [19:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic [5:0] op, input logic z, input logic n, input logic rdy,
                     input logic [3:0] st, input logic [19:0] ctl);
    vec_t v;
    v.op = op; v.z = z; v.n = n; v.rdy = rdy; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic z, input logic n, input logic rdy);
    opcode = op; zero = z; neg = n; mem_ready = rdy;
  endtask

  initial begin
    // R-type: 4 cycles
    add(6'h00, 0, 0, 1, 4'd0, F_GO);
    add(6'h00, 0, 0, 1, 4'd1, BSRC3);
    add(6'h00, 0, 0, 1, 4'd2, ASA | OP2);
    add(6'h00, 0, 0, 1, 4'd4, RGW | RD1);
    // lw with two MEM stall cycles: 7 cycles
    add(6'h23, 0, 0, 1, 4'd0, F_GO);
    add(6'h23, 0, 0, 1, 4'd1, BSRC3);
    add(6'h23, 0, 0, 1, 4'd2, ASA | BSRC2);
    add(6'h23, 0, 0, 0, 4'd3, IORD | MRD);
    add(6'h23, 0, 0, 0, 4'd3, IORD | MRD);
    add(6'h23, 0, 0, 1, 4'd3, IORD | MRD);
    add(6'h23, 0, 0, 1, 4'd4, RGW | MTR1);
    // sw with one FETCH stall
    add(6'h2B, 0, 0, 0, 4'd0, F_STALL);
    add(6'h2B, 0, 0, 1, 4'd0, F_GO);
    add(6'h2B, 0, 0, 1, 4'd1, BSRC3);
    add(6'h2B, 0, 0, 1, 4'd2, ASA | BSRC2);
    add(6'h2B, 0, 0, 1, 4'd3, IORD | MWR);
    // beq, zero=0 then zero=1
    add(6'h04, 0, 0, 1, 4'd0, F_GO);
    add(6'h04, 0, 0, 1, 4'd1, BSRC3);
    add(6'h04, 0, 0, 1, 4'd2, ASA | OP1 | PWC | PSRC1);
    add(6'h04, 1, 0, 1, 4'd0, F_GO);
    add(6'h04, 1, 0, 1, 4'd1, BSRC3);
    add(6'h04, 1, 0, 1, 4'd2, ASA | OP1 | PWC | PSRC1);
    // blezal: neg=1, then both clear, then zero=1
    add(6'h16, 0, 1, 1, 4'd0, F_GO);
    add(6'h16, 0, 1, 1, 4'd1, BSRC3);
    add(6'h16, 0, 1, 1, 4'd2, ASA | OP1 | PCW | PSRC1 | RGW | RD2 | MTR2);
    add(6'h16, 0, 0, 1, 4'd0, F_GO);
    add(6'h16, 0, 0, 1, 4'd1, BSRC3);
    add(6'h16, 0, 0, 1, 4'd2, ASA | OP1);
    add(6'h16, 1, 0, 1, 4'd0, F_GO);
    add(6'h16, 1, 0, 1, 4'd1, BSRC3);
    add(6'h16, 1, 0, 1, 4'd2, ASA | OP1 | PCW | PSRC1 | RGW | RD2 | MTR2);
    // nandi
    add(6'h0E, 0, 0, 1, 4'd0, F_GO);
    add(6'h0E, 0, 0, 1, 4'd1, BSRC3);
    add(6'h0E, 0, 0, 1, 4'd2, ASA | BSRC2 | ZX | OP5);
    add(6'h0E, 0, 0, 1, 4'd4, RGW);
    // j, jalpc
    add(6'h02, 0, 0, 1, 4'd0, F_GO);
    add(6'h02, 0, 0, 1, 4'd1, BSRC3 | PCW | PSRC2);
    add(6'h1F, 0, 0, 1, 4'd0, F_GO);
    add(6'h1F, 0, 0, 1, 4'd1, BSRC3 | PCW | PSRC2 | RGW | RD2 | MTR2);
    add(6'h00, 0, 0, 0, 4'd0, F_STALL);

    // Reset: all outputs low, even the FETCH strobes
    rst_n = 1'b0;
    drive(6'h00, 0, 0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_ctl", {12'd0, act}, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].z, vecs[i].n, vecs[i].rdy);
      @(negedge clk);
`ifdef MULTICYCLE_CTRL_PERF_EN
      if (i == 4) begin
        chk("perf_cycle_rtype", cycle_cnt, 32'd4);
        chk("perf_retire_rtype", retire_cnt, 32'd1);
      end
`endif
      chk($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, vecs[i].st});
      chk($sformatf("vec%0d_ctl", i), {12'd0, act}, {12'd0, vecs[i].ctl});
      chk($sformatf("vec%0d_illegal", i), {31'd0, illegal}, 32'd0);
      @(posedge clk); #1;
    end

    // Unknown opcode: FETCH, DECODE, then parked in TRAP
    drive(6'h3F, 0, 0, 1);
    @(negedge clk);
    chk("trap_fetch_ctl", {12'd0, act}, {12'd0, F_GO});
    @(posedge clk); #1;
    @(negedge clk);
    chk("trap_decode_state", {28'd0, state}, 32'd1);
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      drive(6'h00, c[0], c[1], c[2]);
      @(negedge clk);
      chk($sformatf("trap%0d_state", c), {28'd0, state}, 32'd15);
      chk($sformatf("trap%0d_ctl", c), {12'd0, act}, 32'd0);
      chk($sformatf("trap%0d_illegal", c), {31'd0, illegal}, 32'd1);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("trap_rst_state", {28'd0, state}, 32'd0);
    chk("trap_rst_illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(6'h2B, 0, 0, 1);
    @(negedge clk);
    chk("post_trap_state", {28'd0, state}, 32'd0);
    chk("post_trap_ctl", {12'd0, act}, {12'd0, F_GO});
    @(posedge clk); #1;

    // sw stalled in MEM, then reset mid-access
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_mem_state", {28'd0, state}, 32'd3);
    chk("sw_mem_ctl", {12'd0, act}, {12'd0, IORD | MWR});
    #2;
    rst_n = 1'b0;
    #1;
    chk("sw_abort_state", {28'd0, state}, 32'd0);
    chk("sw_abort_ctl", {12'd0, act}, 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("sw_abort_cycle_cnt", cycle_cnt, 32'd0);
    chk("sw_abort_retire_cnt", retire_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    chk("sw_abort_hold_ctl", {12'd0, act}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
